// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that lets four requesters share one UART
//               transmitter, tracking launch, busy and done with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int TX_PULSE     = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    input  logic       tx_busy,
    output logic       tx_transmit,
    output logic [7:0] tx_data,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       active,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] c_pulse_len = 4'(TX_PULSE);
    localparam logic [7:0] c_to_last   = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t     r_state,       w_state_nxt;
    logic [3:0] r_pulse_cnt,   w_pulse_cnt_nxt;
    logic [7:0] r_to_cnt,      w_to_cnt_nxt;
    logic [1:0] r_last,        w_last_nxt;
    logic       r_busy_seen,   w_busy_seen_nxt;
    logic       r_tx_transmit, w_tx_transmit_nxt;
    logic [7:0] r_tx_data,     w_tx_data_nxt;
    logic [3:0] r_grant,       w_grant_nxt;
    logic [1:0] r_owner,       w_owner_nxt;
    logic       r_active,      w_active_nxt;
    logic       r_done,        w_done_nxt;
    logic       r_error,       w_error_nxt;

    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_idx;
    logic [7:0] w_sel_data;

    // Scan offsets from farthest to nearest so the nearest requester after
    // the last grant wins; offset 4 wraps to the last-granted index itself.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = r_last;
        for (int o = 4; o >= 1; o--) begin
            w_idx = r_last + 2'(o);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        case (w_sel)
            2'd0:    w_sel_data = data_0;
            2'd1:    w_sel_data = data_1;
            2'd2:    w_sel_data = data_2;
            default: w_sel_data = data_3;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pulse_cnt_nxt   = r_pulse_cnt;
        w_to_cnt_nxt      = r_to_cnt;
        w_last_nxt        = r_last;
        w_busy_seen_nxt   = r_busy_seen;
        w_tx_transmit_nxt = r_tx_transmit;
        w_tx_data_nxt     = r_tx_data;
        w_owner_nxt       = r_owner;
        w_active_nxt      = r_active;
        w_grant_nxt       = 4'b0000;
        w_done_nxt        = 1'b0;
        w_error_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy_seen_nxt = 1'b0;
                if (w_found && !tx_busy) begin
                    w_state_nxt       = LAUNCH;
                    w_tx_data_nxt     = w_sel_data;
                    w_owner_nxt       = w_sel;
                    w_grant_nxt       = 4'b0001 << w_sel;
                    w_last_nxt        = w_sel;
                    w_tx_transmit_nxt = 1'b1;
                    w_active_nxt      = 1'b1;
                    w_pulse_cnt_nxt   = 4'd1;
                end
            end
            LAUNCH: begin
                // A busy that rises while the strobe is still high counts.
                if (tx_busy) begin
                    w_busy_seen_nxt = 1'b1;
                end
                if (r_pulse_cnt >= c_pulse_len) begin
                    w_tx_transmit_nxt = 1'b0;
                    w_to_cnt_nxt      = 8'd0;
                    w_state_nxt       = WAIT_BUSY;
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt + 4'd1;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy || r_busy_seen) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_to_cnt >= c_to_last) begin
                    w_error_nxt  = 1'b1;
                    w_active_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end else if (r_to_cnt != 8'hFF) begin
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
            end
            default: begin
                if (!tx_busy) begin
                    w_done_nxt   = 1'b1;
                    w_active_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
        endcase
    end

    // Pointer resets to 3 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pulse_cnt   <= 4'd0;
            r_to_cnt      <= 8'd0;
            r_last        <= 2'd3;
            r_busy_seen   <= 1'b0;
            r_tx_transmit <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant       <= 4'b0000;
            r_owner       <= 2'd0;
            r_active      <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pulse_cnt   <= w_pulse_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_last        <= w_last_nxt;
            r_busy_seen   <= w_busy_seen_nxt;
            r_tx_transmit <= w_tx_transmit_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_grant       <= w_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_active      <= w_active_nxt;
            r_done        <= w_done_nxt;
            r_error       <= w_error_nxt;
        end
    end

    assign tx_transmit = r_tx_transmit;
    assign tx_data     = r_tx_data;
    assign grant       = r_grant;
    assign owner       = r_owner;
    assign active      = r_active;
    assign done        = r_done;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter against a
//               transaction-level timing and round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_p = 2;
    localparam int c_t = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] data [4];
    logic       tx_busy;
    logic       tx_transmit;
    logic [7:0] tx_data;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       active;
    logic       done;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_last = 3;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .TX_PULSE     (c_p),
        .BUSY_TIMEOUT (c_t)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data_0      (data[0]),
        .data_1      (data[1]),
        .data_2      (data[2]),
        .data_3      (data[3]),
        .tx_busy     (tx_busy),
        .tx_transmit (tx_transmit),
        .tx_data     (tx_data),
        .grant       (grant),
        .owner       (owner),
        .active      (active),
        .done        (done),
        .error       (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tx_transmit"}, 32'(tx_transmit), 0);
        chk({tag, ".tx_data"},     32'(tx_data),     0);
        chk({tag, ".grant"},       32'(grant),       0);
        chk({tag, ".owner"},       32'(owner),       0);
        chk({tag, ".active"},      32'(active),      0);
        chk({tag, ".done"},        32'(done),        0);
        chk({tag, ".error"},       32'(error),       0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    endtask

    // One transaction from an IDLE negedge. d: cycles from strobe fall to busy
    // rise (-1 = never), l: busy length, abort_at: cycle to assert reset (-1 none).
    task automatic txn(input logic [3:0] mask, input int d, input int l, input int abort_at);
        int g, n_end, b_on, b_off;
        bit to;
        logic [7:0] exp_data;
        g = -1;
        for (int o = 1; o <= 4; o++) begin
            if (g < 0 && mask[(rr_last + o) % 4]) g = (rr_last + o) % 4;
        end
        req = mask;
        tx_busy = 1'b0;
        if (g < 0) begin
            @(negedge clk);
            chk("idle_grant",  32'(grant),  0);
            chk("idle_active", 32'(active), 0);
            return;
        end
        exp_data = data[g];
        rr_last  = g;
        to       = (d < 0) || (((d < 1) ? 1 : d) > c_t);
        n_end    = to ? (c_p + c_t) : (c_p + d + l);
        b_on     = (d < 0) ? 32'h4000_0000 : (c_p + d - 1);
        b_off    = b_on + l;
        for (int n = 0; n <= n_end; n++) begin
            @(negedge clk);
            chk("grant",       32'(grant),       (n == 0) ? (32'd1 << g) : 0);
            chk("tx_transmit", 32'(tx_transmit), 32'(n < c_p));
            chk("tx_data",     32'(tx_data),     32'(exp_data));
            chk("owner",       32'(owner),       32'(g));
            chk("active",      32'(active),      32'(n < n_end));
            chk("done",        32'(done),        32'(!to && n == n_end));
            chk("error",       32'(error),       32'(to && n == n_end));
            if (n == abort_at) begin
                reset   = 1'b0;
                tx_busy = 1'b0;
                req     = 4'b0000;
                @(negedge clk);
                chk_reset("abort");
                reset   = 1'b1;
                rr_last = 3;
                return;
            end
            tx_busy = (n >= b_on) && (n < b_off);
            rand_data();
            req = 4'($urandom);
        end
    endtask

    task automatic blocked(input logic [3:0] mask, input int cycles);
        req     = mask;
        tx_busy = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("blocked_grant",  32'(grant),  0);
            chk("blocked_active", 32'(active), 0);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        req     = 4'b0000;
        tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset = 1'b1;

        txn(4'b0000, 1, 3, -1);

        data[0] = 8'hA5;
        txn(4'b0001, 1, 100, -1);

        for (int i = 0; i < 4; i++) data[i] = 8'h10 + 8'(i);
        repeat (5) txn(4'b1111, 1, 3, -1);

        rand_data();
        txn(4'b0100, -1, 0, -1);

        blocked(4'b0010, 3);
        rand_data();
        txn(4'b0010, 1, 4, -1);

        rand_data();
        txn(4'b0110, 0, 2, -1);
        rand_data();
        txn(4'b1001, c_t, 2, -1);

        rand_data();
        txn(4'b0101, 2, 100, c_p + 3);
        rand_data();
        txn(4'b1000, 1, 4, -1);

        data[1] = 8'h3C;
        txn(4'b0010, 1, 5, -1);

        for (int k = 0; k < 40; k++) begin
            int d;
            rand_data();
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, c_t));
            if ($urandom_range(0, 5) == 0) blocked(4'($urandom), int'($urandom_range(1, 3)));
            txn(4'($urandom), d, int'($urandom_range(2, 12)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
